analog_sensor_reader: RTL and testbench
=======================================

ANALOG_SENSOR_READER -- requirements
Module: analog_sensor_reader

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 64: maximum cycles to wait for AnalogValReady.
REQ-002 SHALL have parameter FIFO_DEPTH, default 4: number of captured-sample entries, power of two.
REQ-003 SHALL have port Clk  in  1: single clock; all state on its rising edge.
REQ-004 SHALL have port Reset_n  in  1: asynchronous, active-low reset.
REQ-005 SHALL have port Start  in  1: one-cycle host pulse that begins polling.
REQ-006 SHALL have port Continuous  in  1: 1 = poll repeatedly; 0 = take one sample and stop.
REQ-007 SHALL have port PollMode  in  2: sensor mode to request (01 fast, 10 slow); 00/11 treated as 10.
REQ-008 SHALL have port PollInterval  in  16: gap cycles between successive polls.
REQ-009 SHALL have port Abort  in  1: stop polling and return to IDLE.
REQ-010 SHALL have port AnalogReading  in  16: sensor data; bits [11:0] significant.
REQ-011 SHALL have port AnalogValReady  in  1: sensor data valid.
REQ-012 SHALL have port Mode  out  2: mode driven to the sensor.
REQ-013 SHALL have port Enable  out  1: sensor enable.
REQ-014 SHALL have port CPUReadComplete  out  1: one-cycle read acknowledge to the sensor.
REQ-015 SHALL have port HostPop  in  1: pop the FIFO head.
REQ-016 SHALL have port HostClear  in  1: clear sticky flags.
REQ-017 SHALL have port HostData  out  12: FIFO head.
REQ-018 SHALL have port HostValid  out  1: FIFO non-empty.
REQ-019 SHALL have port FifoCount  out  $clog2(FIFO_DEPTH)+1: current occupancy.
REQ-020 SHALL have ports Overflow  out  1 and Timeout  out  1: sticky error flags.
REQ-021 SHALL have port Busy  out  1: FSM not in IDLE.

Function
REQ-022 FSM states SHALL be IDLE, ARM, WAIT_READY, ACK, GAP, all outputs registered.
REQ-023 IDLE: Enable=0, Mode=00; on Start go to ARM and latch PollMode, Continuous, PollInterval.
REQ-024 ARM: Enable=1, Mode=latched mode for exactly one cycle, then WAIT_READY.
REQ-025 WAIT_READY: on AnalogValReady=1 SHALL push AnalogReading[11:0] on that edge and go to ACK.
REQ-026 ACK: CPUReadComplete=1 for exactly one cycle; next state GAP if Continuous latched, else IDLE.
REQ-027 GAP: count latched PollInterval cycles (0 = zero gap), then WAIT_READY; Enable and Mode held.
REQ-028 Timeout counter SHALL run only in WAIT_READY; upon reaching TIMEOUT_CYCLES with no ready, set Timeout and go to IDLE.
REQ-029 Push into a full FIFO SHALL drop the sample and set Overflow; ACK still issued.
REQ-030 Simultaneous push and pop when full SHALL succeed with count unchanged and no overflow.
REQ-031 Pop when empty SHALL be ignored; HostData undefined-free: holds last head value.
REQ-032 Abort SHALL force IDLE next edge from any state, suppressing any pending CPUReadComplete; FIFO contents kept.
REQ-033 Start while Busy SHALL be ignored; HostClear with simultaneous error event SHALL leave the flag set.

Reset
REQ-034 Reset_n low SHALL force IDLE, Mode=00, Enable=0, CPUReadComplete=0, FIFO empty, HostData=0, Overflow=0, Timeout=0, counters 0.

Configuration
REQ-035 With READER_MINMAX_EN defined, SHALL add outputs MinReading, MaxReading (12 bits), updated on every accepted push (including dropped samples), reset to FFF/000, cleared to those values by HostClear.
REQ-036 Without READER_MINMAX_EN, those ports and registers SHALL not exist.

Structure
REQ-037 Package analog_sensor_pkg SHALL hold sensor mode constants (STOP, FAST, SLOW), sensor error-code constants, and the reader state enum.
REQ-038 FIFO SHALL be a separate sub-module reader_fifo (push, pop, full, empty, count).

Verification
REQ-039 Single slow poll: Start, PollMode=10, Continuous=0; ready after 3 cycles with 0x0ABC -> HostData=0xABC, one CPUReadComplete pulse, Busy low.
REQ-040 Continuous fast, PollInterval=5, ready held high -> pushes exactly 6 cycles apart, ACK pulses each single-cycle.
REQ-041 Never assert ready, TIMEOUT_CYCLES=64 -> Timeout set after 64 WAIT_READY cycles, Enable=0, FIFO empty.
REQ-042 Five samples with no pops, depth 4 -> FifoCount=4, Overflow=1, head = first sample; HostClear clears Overflow.
REQ-043 Abort during WAIT_READY and Reset_n low during ACK -> IDLE next edge, no CPUReadComplete pulse, reset values per REQ-034.

Source files
------------

// File: rtl/analog_sensor_pkg.sv
// analog_sensor_pkg: sensor mode codes, sticky error codes and the reader
// state type shared by analog_sensor_reader and its FIFO.
package analog_sensor_pkg;

    // Mode codes driven to the sensor
    localparam logic [1:0] MODE_STOP = 2'b00;
    localparam logic [1:0] MODE_FAST = 2'b01;
    localparam logic [1:0] MODE_SLOW = 2'b10;

    // One-hot error codes; each bit is one sticky flag
    localparam logic [1:0] ERR_NONE     = 2'b00;
    localparam logic [1:0] ERR_TIMEOUT  = 2'b01;
    localparam logic [1:0] ERR_OVERFLOW = 2'b10;

    // Significant bits of a sensor reading
    localparam int unsigned SAMPLE_W = 12;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ARM,
        ST_WAIT_READY,
        ST_ACK,
        ST_GAP
    } reader_state_e;

    // Only the fast code selects fast mode; every other request polls slow
    function automatic logic [1:0] decode_mode(input logic [1:0] req);
        return (req == MODE_FAST) ? MODE_FAST : MODE_SLOW;
    endfunction

endpackage

// File: rtl/reader_fifo.sv
// reader_fifo: sample FIFO, DEPTH a power of two. A push into a full FIFO is
// dropped unless a pop happens on the same edge. When empty, data_o keeps
// the last head value that was popped (zero after reset).
module reader_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 12
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     push_i,
    input  logic [WIDTH-1:0]         data_i,
    input  logic                     pop_i,
    output logic [WIDTH-1:0]         data_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]    count_q;
    logic [WIDTH-1:0] last_q;
    logic             do_push, do_pop;

    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == CW'(DEPTH));
    assign count_o = count_q;
    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);
    assign data_o  = empty_o ? last_q : mem_q[rd_ptr_q];

    // Storage array: written on accepted pushes only
    always_ff @(posedge clk_i) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= data_i;
        end
    end

    // Pointers, occupancy and the held head value
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            last_q   <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
                last_q   <= mem_q[rd_ptr_q];
            end
            if (do_push && !do_pop) begin
                count_q <= count_q + 1'b1;
            end else if (!do_push && do_pop) begin
                count_q <= count_q - 1'b1;
            end
        end
    end

endmodule

// File: rtl/analog_sensor_reader.sv
// analog_sensor_reader: polls an analog sensor (single-shot or continuous),
// buffers 12-bit readings in a FIFO for the host and keeps sticky timeout and
// overflow flags. Optional READER_MINMAX_EN adds MinReading/MaxReading.
module analog_sensor_reader
    import analog_sensor_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 64,
    parameter int unsigned FIFO_DEPTH     = 4
) (
    input  logic                          Clk,
    input  logic                          Reset_n,
    input  logic                          Start,
    input  logic                          Continuous,
    input  logic [1:0]                    PollMode,
    input  logic [15:0]                   PollInterval,
    input  logic                          Abort,
    input  logic [15:0]                   AnalogReading,
    input  logic                          AnalogValReady,
    output logic [1:0]                    Mode,
    output logic                          Enable,
    output logic                          CPUReadComplete,
    input  logic                          HostPop,
    input  logic                          HostClear,
    output logic [SAMPLE_W-1:0]           HostData,
    output logic                          HostValid,
    output logic [$clog2(FIFO_DEPTH):0]   FifoCount,
    output logic                          Overflow,
    output logic                          Timeout,
    output logic                          Busy
`ifdef READER_MINMAX_EN
    ,
    output logic [SAMPLE_W-1:0]           MinReading,
    output logic [SAMPLE_W-1:0]           MaxReading
`endif
);

    localparam int unsigned   TW       = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

    reader_state_e       state_q;
    logic [1:0]          mode_q;
    logic                enable_q, ack_q, busy_q, cont_q;
    logic [15:0]         intv_q, gap_cnt_q;
    logic [TW-1:0]       tmo_cnt_q;
    logic [1:0]          err_q, err_evt;
    logic                push, tmo_hit, ovf_evt, fifo_full, fifo_empty;
    logic [SAMPLE_W-1:0] sample;
    logic                unused_reading_hi;

    assign sample            = AnalogReading[SAMPLE_W-1:0];
    assign unused_reading_hi = ^AnalogReading[15:SAMPLE_W];

    // Abort outranks both a ready sample and an expiring timeout
    assign push    = (state_q == ST_WAIT_READY) && AnalogValReady && !Abort;
    assign tmo_hit = (state_q == ST_WAIT_READY) && !AnalogValReady && !Abort
                     && (tmo_cnt_q == TMO_LAST);
    assign ovf_evt = push && fifo_full && !HostPop;
    assign err_evt = (tmo_hit ? ERR_TIMEOUT : ERR_NONE)
                   | (ovf_evt ? ERR_OVERFLOW : ERR_NONE);

    assign Mode            = mode_q;
    assign Enable          = enable_q;
    assign CPUReadComplete = ack_q;
    assign Busy            = busy_q;
    assign Timeout         = |(err_q & ERR_TIMEOUT);
    assign Overflow        = |(err_q & ERR_OVERFLOW);
    assign HostValid       = !fifo_empty;

    reader_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (SAMPLE_W)
    ) u_fifo (
        .clk_i   (Clk),
        .rst_ni  (Reset_n),
        .push_i  (push),
        .data_i  (sample),
        .pop_i   (HostPop),
        .data_o  (HostData),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (FifoCount)
    );

    // Poll sequencer with registered sensor-side outputs.
    // The ACK cycle counts as the first gap cycle, so consecutive samples
    // are PollInterval+1 cycles apart (minimum 2).
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q   <= ST_IDLE;
            mode_q    <= MODE_STOP;
            enable_q  <= 1'b0;
            ack_q     <= 1'b0;
            busy_q    <= 1'b0;
            cont_q    <= 1'b0;
            intv_q    <= '0;
            gap_cnt_q <= '0;
            tmo_cnt_q <= '0;
        end else begin
            ack_q <= 1'b0;
            if (Abort) begin
                state_q   <= ST_IDLE;
                mode_q    <= MODE_STOP;
                enable_q  <= 1'b0;
                busy_q    <= 1'b0;
                gap_cnt_q <= '0;
                tmo_cnt_q <= '0;
            end else begin
                case (state_q)
                    ST_IDLE: begin
                        if (Start) begin
                            state_q  <= ST_ARM;
                            mode_q   <= decode_mode(PollMode);
                            enable_q <= 1'b1;
                            busy_q   <= 1'b1;
                            cont_q   <= Continuous;
                            intv_q   <= PollInterval;
                        end
                    end
                    ST_ARM: begin
                        state_q   <= ST_WAIT_READY;
                        tmo_cnt_q <= '0;
                    end
                    ST_WAIT_READY: begin
                        if (AnalogValReady) begin
                            state_q   <= ST_ACK;
                            ack_q     <= 1'b1;
                            tmo_cnt_q <= '0;
                        end else if (tmo_hit) begin
                            state_q   <= ST_IDLE;
                            mode_q    <= MODE_STOP;
                            enable_q  <= 1'b0;
                            busy_q    <= 1'b0;
                            tmo_cnt_q <= '0;
                        end else begin
                            tmo_cnt_q <= tmo_cnt_q + 1'b1;
                        end
                    end
                    ST_ACK: begin
                        if (!cont_q) begin
                            state_q  <= ST_IDLE;
                            mode_q   <= MODE_STOP;
                            enable_q <= 1'b0;
                            busy_q   <= 1'b0;
                        end else if (intv_q < 16'd2) begin
                            state_q <= ST_WAIT_READY;
                        end else begin
                            state_q   <= ST_GAP;
                            gap_cnt_q <= 16'd1;
                        end
                    end
                    ST_GAP: begin
                        if (gap_cnt_q == intv_q - 16'd1) begin
                            state_q   <= ST_WAIT_READY;
                            gap_cnt_q <= '0;
                        end else begin
                            gap_cnt_q <= gap_cnt_q + 16'd1;
                        end
                    end
                    default: begin
                        state_q  <= ST_IDLE;
                        mode_q   <= MODE_STOP;
                        enable_q <= 1'b0;
                        busy_q   <= 1'b0;
                    end
                endcase
            end
        end
    end

    // Sticky flags: a new error event on the clearing edge keeps its flag set
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            err_q <= ERR_NONE;
        end else begin
            err_q <= (HostClear ? ERR_NONE : err_q) | err_evt;
        end
    end

`ifdef READER_MINMAX_EN
    logic [SAMPLE_W-1:0] min_q, max_q, min_base, max_base;

    assign MinReading = min_q;
    assign MaxReading = max_q;

    // Clear is applied first, so a sample on the clearing edge still counts
    always_comb begin
        min_base = HostClear ? '1 : min_q;
        max_base = HostClear ? '0 : max_q;
    end

    // Running extremes over every sample offered to the FIFO, dropped or not
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            min_q <= '1;
            max_q <= '0;
        end else if (push) begin
            min_q <= (sample < min_base) ? sample : min_base;
            max_q <= (sample > max_base) ? sample : max_base;
        end else begin
            min_q <= min_base;
            max_q <= max_base;
        end
    end
`endif

endmodule

// File: tb/tb_analog_sensor_reader.sv
// tb_analog_sensor_reader: directed tests for analog_sensor_reader (default build).
module tb_analog_sensor_reader;

    logic        Clk, Reset_n, Start, Continuous, Abort, AnalogValReady, HostPop, HostClear;
    logic [1:0]  PollMode;
    logic [15:0] PollInterval, AnalogReading;
    logic [1:0]  Mode;
    logic        Enable, CPUReadComplete, HostValid, Overflow, Timeout, Busy;
    logic [11:0] HostData;
    logic [2:0]  FifoCount;

    int nvec = 0;
    int nerr = 0;

    analog_sensor_reader #(
        .TIMEOUT_CYCLES (64),
        .FIFO_DEPTH     (4)
    ) dut (
        .Clk             (Clk),
        .Reset_n         (Reset_n),
        .Start           (Start),
        .Continuous      (Continuous),
        .PollMode        (PollMode),
        .PollInterval    (PollInterval),
        .Abort           (Abort),
        .AnalogReading   (AnalogReading),
        .AnalogValReady  (AnalogValReady),
        .Mode            (Mode),
        .Enable          (Enable),
        .CPUReadComplete (CPUReadComplete),
        .HostPop         (HostPop),
        .HostClear       (HostClear),
        .HostData        (HostData),
        .HostValid       (HostValid),
        .FifoCount       (FifoCount),
        .Overflow        (Overflow),
        .Timeout         (Timeout),
        .Busy            (Busy)
    );

    initial begin
        Clk = 1'b0;
        forever #5 Clk = ~Clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got timeout exp finish");
        $fatal(1, "watchdog expired");
    end

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    task automatic poll_once(input logic [15:0] val, input logic clr, input logic pop,
                             output logic ack_seen);
        PollMode = 2'b10; Continuous = 1'b0; Start = 1'b1;
        step(); Start = 1'b0;
        step();
        AnalogValReady = 1'b1; AnalogReading = val; HostClear = clr; HostPop = pop;
        step();
        ack_seen = CPUReadComplete;
        AnalogValReady = 1'b0; HostClear = 1'b0; HostPop = 1'b0;
        step();
    endtask

    task automatic test_reset();
        Reset_n = 1'b0;
        step(); step();
        nvec++; if (Mode !== 2'b00) begin nerr++; $display("FAIL reset_mode got %b exp 00", Mode); end
        nvec++; if (Enable !== 1'b0) begin nerr++; $display("FAIL reset_enable got %b exp 0", Enable); end
        nvec++; if (CPUReadComplete !== 1'b0) begin nerr++; $display("FAIL reset_ack got %b exp 0", CPUReadComplete); end
        nvec++; if (HostValid !== 1'b0) begin nerr++; $display("FAIL reset_valid got %b exp 0", HostValid); end
        nvec++; if (HostData !== 12'h000) begin nerr++; $display("FAIL reset_data got %h exp 000", HostData); end
        nvec++; if (FifoCount !== 3'd0) begin nerr++; $display("FAIL reset_count got %0d exp 0", FifoCount); end
        nvec++; if (Overflow !== 1'b0) begin nerr++; $display("FAIL reset_ovf got %b exp 0", Overflow); end
        nvec++; if (Timeout !== 1'b0) begin nerr++; $display("FAIL reset_tmo got %b exp 0", Timeout); end
        nvec++; if (Busy !== 1'b0) begin nerr++; $display("FAIL reset_busy got %b exp 0", Busy); end
        Reset_n = 1'b1;
        step();
    endtask

    task automatic test_single_slow();
        PollMode = 2'b10; Continuous = 1'b0; Start = 1'b1;
        step(); Start = 1'b0;
        nvec++; if (Busy !== 1'b1) begin nerr++; $display("FAIL arm_busy got %b exp 1", Busy); end
        nvec++; if (Enable !== 1'b1) begin nerr++; $display("FAIL arm_enable got %b exp 1", Enable); end
        nvec++; if (Mode !== 2'b10) begin nerr++; $display("FAIL arm_mode got %b exp 10", Mode); end
        step();
        PollMode = 2'b01; Start = 1'b1;
        step(); Start = 1'b0; PollMode = 2'b10;
        nvec++; if (Mode !== 2'b10) begin nerr++; $display("FAIL start_while_busy_mode got %b exp 10", Mode); end
        step();
        AnalogValReady = 1'b1; AnalogReading = 16'h0ABC;
        step(); AnalogValReady = 1'b0; AnalogReading = 16'h0000;
        nvec++; if (CPUReadComplete !== 1'b1) begin nerr++; $display("FAIL single_ack got %b exp 1", CPUReadComplete); end
        nvec++; if (HostData !== 12'hABC) begin nerr++; $display("FAIL single_data got %h exp abc", HostData); end
        nvec++; if (FifoCount !== 3'd1) begin nerr++; $display("FAIL single_count got %0d exp 1", FifoCount); end
        step();
        nvec++; if (CPUReadComplete !== 1'b0) begin nerr++; $display("FAIL single_ack_end got %b exp 0", CPUReadComplete); end
        nvec++; if (Busy !== 1'b0) begin nerr++; $display("FAIL single_busy got %b exp 0", Busy); end
        nvec++; if (Enable !== 1'b0) begin nerr++; $display("FAIL single_enable got %b exp 0", Enable); end
        nvec++; if (Mode !== 2'b00) begin nerr++; $display("FAIL single_mode got %b exp 00", Mode); end
        HostPop = 1'b1; step(); HostPop = 1'b0;
        nvec++; if (HostValid !== 1'b0) begin nerr++; $display("FAIL pop_valid got %b exp 0", HostValid); end
        nvec++; if (HostData !== 12'hABC) begin nerr++; $display("FAIL pop_hold got %h exp abc", HostData); end
        HostPop = 1'b1; step(); HostPop = 1'b0;
        nvec++; if (FifoCount !== 3'd0) begin nerr++; $display("FAIL empty_pop_count got %0d exp 0", FifoCount); end
        nvec++; if (HostData !== 12'hABC) begin nerr++; $display("FAIL empty_pop_hold got %h exp abc", HostData); end
    endtask

    task automatic test_fast_continuous();
        int ack_cyc [3];
        logic [11:0] exp_h [3];
        int nack;
        logic prev_ack;
        exp_h[0] = 12'h102; exp_h[1] = 12'h108; exp_h[2] = 12'h10E;
        for (int k = 0; k < 3; k++) ack_cyc[k] = -1;
        nack = 0; prev_ack = 1'b0;
        PollMode = 2'b01; Continuous = 1'b1; PollInterval = 16'd5; AnalogValReady = 1'b1; Start = 1'b1;
        for (int i = 0; i < 40 && nack < 3; i++) begin
            AnalogReading = {4'hF, 12'h100 + 12'(i)};
            step(); Start = 1'b0;
            nvec++; if (CPUReadComplete && prev_ack) begin nerr++; $display("FAIL ack_width cycle %0d got 2-cycle pulse exp 1-cycle", i); end
            if (i == 5) begin
                nvec++; if (Enable !== 1'b1 || Mode !== 2'b01) begin nerr++; $display("FAIL gap_hold got en=%b mode=%b exp en=1 mode=01", Enable, Mode); end
            end
            if (CPUReadComplete) begin
                ack_cyc[nack] = i;
                nack++;
            end
            prev_ack = CPUReadComplete;
        end
        nvec++; if (nack !== 3) begin nerr++; $display("FAIL fast_ack_count got %0d exp 3", nack); end
        nvec++; if (ack_cyc[0] !== 2) begin nerr++; $display("FAIL fast_first_ack got %0d exp 2", ack_cyc[0]); end
        nvec++; if (ack_cyc[1] !== 8) begin nerr++; $display("FAIL fast_second_ack got %0d exp 8", ack_cyc[1]); end
        nvec++; if (ack_cyc[2] !== 14) begin nerr++; $display("FAIL fast_third_ack got %0d exp 14", ack_cyc[2]); end
        Abort = 1'b1; AnalogValReady = 1'b0;
        step(); Abort = 1'b0; Continuous = 1'b0; PollInterval = 16'd0;
        nvec++; if (Busy !== 1'b0) begin nerr++; $display("FAIL fast_abort_busy got %b exp 0", Busy); end
        nvec++; if (Enable !== 1'b0) begin nerr++; $display("FAIL fast_abort_enable got %b exp 0", Enable); end
        nvec++; if (FifoCount !== 3'd3) begin nerr++; $display("FAIL fast_count got %0d exp 3", FifoCount); end
        for (int k = 0; k < 3; k++) begin
            nvec++; if (HostData !== exp_h[k]) begin nerr++; $display("FAIL fast_data[%0d] got %h exp %h", k, HostData, exp_h[k]); end
            HostPop = 1'b1; step(); HostPop = 1'b0;
        end
        nvec++; if (HostValid !== 1'b0) begin nerr++; $display("FAIL fast_drain_valid got %b exp 0", HostValid); end
    endtask

    task automatic test_timeout();
        int n;
        logic hit;
        n = 0; hit = 1'b0;
        PollMode = 2'b00; Continuous = 1'b0; AnalogValReady = 1'b0; Start = 1'b1;
        step(); Start = 1'b0;
        nvec++; if (Mode !== 2'b10) begin nerr++; $display("FAIL mode00_as_slow got %b exp 10", Mode); end
        step();
        for (int i = 1; i <= 100 && !hit; i++) begin
            step();
            if (Timeout) begin hit = 1'b1; n = i; end
        end
        nvec++; if (n !== 64) begin nerr++; $display("FAIL timeout_cycles got %0d exp 64", n); end
        nvec++; if (Enable !== 1'b0) begin nerr++; $display("FAIL timeout_enable got %b exp 0", Enable); end
        nvec++; if (Busy !== 1'b0) begin nerr++; $display("FAIL timeout_busy got %b exp 0", Busy); end
        nvec++; if (FifoCount !== 3'd0) begin nerr++; $display("FAIL timeout_count got %0d exp 0", FifoCount); end
        HostClear = 1'b1; step(); HostClear = 1'b0;
        nvec++; if (Timeout !== 1'b0) begin nerr++; $display("FAIL timeout_clear got %b exp 0", Timeout); end
    endtask

    task automatic test_overflow();
        logic ack;
        poll_once(16'h0011, 1'b0, 1'b0, ack);
        poll_once(16'h0022, 1'b0, 1'b0, ack);
        poll_once(16'h0033, 1'b0, 1'b0, ack);
        poll_once(16'h0044, 1'b0, 1'b0, ack);
        nvec++; if (Overflow !== 1'b0) begin nerr++; $display("FAIL ovf_before_full got %b exp 0", Overflow); end
        poll_once(16'h0055, 1'b0, 1'b0, ack);
        nvec++; if (ack !== 1'b1) begin nerr++; $display("FAIL ovf_ack got %b exp 1", ack); end
        nvec++; if (FifoCount !== 3'd4) begin nerr++; $display("FAIL ovf_count got %0d exp 4", FifoCount); end
        nvec++; if (Overflow !== 1'b1) begin nerr++; $display("FAIL ovf_flag got %b exp 1", Overflow); end
        nvec++; if (HostData !== 12'h011) begin nerr++; $display("FAIL ovf_head got %h exp 011", HostData); end
        HostClear = 1'b1; step(); HostClear = 1'b0;
        nvec++; if (Overflow !== 1'b0) begin nerr++; $display("FAIL ovf_clear got %b exp 0", Overflow); end
        poll_once(16'h0066, 1'b1, 1'b0, ack);
        nvec++; if (Overflow !== 1'b1) begin nerr++; $display("FAIL clear_vs_event got %b exp 1", Overflow); end
        HostClear = 1'b1; step(); HostClear = 1'b0;
        poll_once(16'h0077, 1'b0, 1'b1, ack);
        nvec++; if (FifoCount !== 3'd4) begin nerr++; $display("FAIL full_pushpop_count got %0d exp 4", FifoCount); end
        nvec++; if (Overflow !== 1'b0) begin nerr++; $display("FAIL full_pushpop_ovf got %b exp 0", Overflow); end
        nvec++; if (HostData !== 12'h022) begin nerr++; $display("FAIL full_pushpop_head got %h exp 022", HostData); end
    endtask

    task automatic test_abort_reset();
        PollMode = 2'b01; Continuous = 1'b0; Start = 1'b1;
        step(); Start = 1'b0;
        step();
        Abort = 1'b1; AnalogValReady = 1'b1; AnalogReading = 16'h0FFF;
        step(); Abort = 1'b0; AnalogValReady = 1'b0;
        nvec++; if (Busy !== 1'b0) begin nerr++; $display("FAIL abort_busy got %b exp 0", Busy); end
        nvec++; if (CPUReadComplete !== 1'b0) begin nerr++; $display("FAIL abort_ack got %b exp 0", CPUReadComplete); end
        nvec++; if (Enable !== 1'b0 || Mode !== 2'b00) begin nerr++; $display("FAIL abort_outputs got en=%b mode=%b exp en=0 mode=00", Enable, Mode); end
        nvec++; if (FifoCount !== 3'd4) begin nerr++; $display("FAIL abort_keep_count got %0d exp 4", FifoCount); end
        nvec++; if (Overflow !== 1'b0) begin nerr++; $display("FAIL abort_no_push got %b exp 0", Overflow); end
        step();
        nvec++; if (CPUReadComplete !== 1'b0) begin nerr++; $display("FAIL abort_ack_late got %b exp 0", CPUReadComplete); end
        Start = 1'b1;
        step(); Start = 1'b0;
        step();
        AnalogValReady = 1'b1; AnalogReading = 16'h0123;
        step(); AnalogValReady = 1'b0;
        nvec++; if (CPUReadComplete !== 1'b1) begin nerr++; $display("FAIL pre_reset_ack got %b exp 1", CPUReadComplete); end
        #1 Reset_n = 1'b0;
        #1;
        nvec++; if (CPUReadComplete !== 1'b0) begin nerr++; $display("FAIL rst_ack got %b exp 0", CPUReadComplete); end
        nvec++; if (Busy !== 1'b0 || Enable !== 1'b0 || Mode !== 2'b00) begin nerr++; $display("FAIL rst_fsm got busy=%b en=%b mode=%b exp 0 0 00", Busy, Enable, Mode); end
        nvec++; if (FifoCount !== 3'd0 || HostValid !== 1'b0) begin nerr++; $display("FAIL rst_fifo got count=%0d valid=%b exp 0 0", FifoCount, HostValid); end
        nvec++; if (HostData !== 12'h000) begin nerr++; $display("FAIL rst_data got %h exp 000", HostData); end
        nvec++; if (Overflow !== 1'b0 || Timeout !== 1'b0) begin nerr++; $display("FAIL rst_flags got ovf=%b tmo=%b exp 0 0", Overflow, Timeout); end
        step(); Reset_n = 1'b1;
        step();
        nvec++; if (Busy !== 1'b0 || CPUReadComplete !== 1'b0) begin nerr++; $display("FAIL post_rst got busy=%b ack=%b exp 0 0", Busy, CPUReadComplete); end
    endtask

    initial begin
        Reset_n = 1'b0; Start = 1'b0; Continuous = 1'b0; Abort = 1'b0;
        AnalogValReady = 1'b0; HostPop = 1'b0; HostClear = 1'b0;
        PollMode = 2'b00; PollInterval = 16'd0; AnalogReading = 16'h0000;
        test_reset();
        test_single_slow();
        test_fast_continuous();
        test_timeout();
        test_overflow();
        test_abort_reset();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
